// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: trigger-qualified, decimated ADC frame capture sequencer.
// Optional macro CAPTURE_TRIG_TIMEOUT_EN adds cfg_timeout / timed_out.
module adc_capture_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DECIM_W   = 8,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic                 cfg_src_sel,
  input  logic [ADDR_W:0]      cfg_len,
  input  logic [DECIM_W-1:0]   cfg_decim,
  input  logic [1:0]           cfg_trig_mode,
`ifdef CAPTURE_TRIG_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 timed_out,
`endif
  input  logic                 ext_trig,
  input  logic                 adc_valid,
  output logic                 buf_wr_en,
  output logic [ADDR_W-1:0]    buf_wr_addr,
  output logic                 src_sel,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      frames_captured,
  input  logic                 rd_release
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] L_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic                r_hit;
  logic [ADDR_W:0]     r_len;
  logic [DECIM_W-1:0]  r_decim;
  logic [DECIM_W-1:0]  r_dcnt;
  logic [1:0]          r_mode;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_src;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_fc;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tcnt;
  logic                 r_tmo;
`else
  // No timeout counter in this build; WAIT_TRIG waits indefinitely.
  if (TIMEOUT_W < 1) begin : g_no_timeout
  end
`endif

  logic [ADDR_W:0] w_len;
  logic            w_imm;
  logic            w_edge;
  logic            w_qual;
  logic [ADDR_W:0] w_fc_inc;

  // Zero length and anything past full depth both mean a full buffer.
  assign w_len = (cfg_len == '0 || cfg_len > L_FULL) ? L_FULL : cfg_len;
  assign w_imm = (cfg_trig_mode == 2'd0) || (cfg_trig_mode == 2'd3);
  assign w_edge = (r_mode == 2'd1) ? (r_s2 & ~r_s3) :
                  (r_mode == 2'd2) ? (~r_s2 & r_s3) : 1'b0;
  assign w_qual = (r_state == S_CAP) && adc_valid &&
                  (r_dcnt == '0) && !cfg_abort;
  assign w_fc_inc = r_fc + (ADDR_W+1)'(1);

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ext_trig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Capture FSM with registered strobes, address and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hit   <= 1'b0;
      r_len   <= '0;
      r_decim <= '0;
      r_dcnt  <= '0;
      r_mode  <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_src   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fc    <= '0;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
      r_tcnt  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_wr_en <= w_qual;
      if (r_wr_en) r_addr <= r_addr + ADDR_W'(1);
      r_hit <= (r_state == S_WAIT) && w_edge && !cfg_abort;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
      if (rd_release) r_tmo <= 1'b0;
`endif
      if (cfg_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (cfg_start) begin
              r_src   <= cfg_src_sel;
              r_len   <= w_len;
              r_decim <= cfg_decim;
              r_mode  <= cfg_trig_mode;
              r_addr  <= '0;
              r_fc    <= '0;
              r_dcnt  <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= w_imm ? S_CAP : S_WAIT;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
              r_tcnt  <= cfg_timeout;
              r_tmo   <= 1'b0;
`endif
            end else if (rd_release) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
            end
          end
          S_WAIT: begin
`ifdef CAPTURE_TRIG_TIMEOUT_EN
            if (r_tcnt != '0) r_tcnt <= r_tcnt - TIMEOUT_W'(1);
`endif
            if (r_hit) begin
              r_state <= S_CAP;
            end
`ifdef CAPTURE_TRIG_TIMEOUT_EN
            else if (r_tcnt == TIMEOUT_W'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_tmo   <= 1'b1;
            end
`endif
          end
          S_CAP: begin
            if (adc_valid) begin
              r_dcnt <= (r_dcnt == '0) ? r_decim :
                        r_dcnt - DECIM_W'(1);
            end
            if (w_qual) begin
              r_fc <= w_fc_inc;
              if (w_fc_inc == r_len) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign buf_wr_en       = r_wr_en;
  assign buf_wr_addr     = r_addr;
  assign src_sel         = r_src;
  assign busy            = r_busy;
  assign done            = r_done;
  assign frames_captured = r_fc;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
  assign timed_out       = r_tmo;
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: randomized scoreboard bench for adc_capture_ctrl.
// Reference model counts valid frames and decimation with plain arithmetic.
module tb_adc_capture_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TW = 24;

  logic          clk;
  logic          reset;
  logic          cfg_start;
  logic          cfg_abort;
  logic          cfg_src_sel;
  logic [AW:0]   cfg_len;
  logic [DW-1:0] cfg_decim;
  logic [1:0]    cfg_trig_mode;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
  logic [TW-1:0] cfg_timeout;
  logic          timed_out;
`endif
  logic          ext_trig;
  logic          adc_valid;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic          src_sel;
  logic          busy;
  logic          done;
  logic [AW:0]   frames_captured;
  logic          rd_release;

  int n_pass = 0;
  int n_tot  = 0;
  logic [AW-1:0] exp_q[$];

  adc_capture_ctrl #(
    .ADDR_W(AW), .DECIM_W(DW), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_src_sel(cfg_src_sel),
    .cfg_len(cfg_len),
    .cfg_decim(cfg_decim),
    .cfg_trig_mode(cfg_trig_mode),
`ifdef CAPTURE_TRIG_TIMEOUT_EN
    .cfg_timeout(cfg_timeout),
    .timed_out(timed_out),
`endif
    .ext_trig(ext_trig),
    .adc_valid(adc_valid),
    .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .src_sel(src_sel),
    .busy(busy),
    .done(done),
    .frames_captured(frames_captured),
    .rd_release(rd_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // Monitor: every write strobe must match the next expected address.
  always @(negedge clk) begin
    if (!reset && buf_wr_en !== 1'b0) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: wr_en=%b addr %0d, required no write",
                 buf_wr_en, buf_wr_addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (buf_wr_en === 1'b1 && buf_wr_addr === e) n_pass++;
        else $display("FAIL wr_addr: got %0d, required %0d",
                      buf_wr_addr, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_cfg();
    cfg_src_sel   = 1'($urandom);
    cfg_len       = (AW+1)'($urandom);
    cfg_decim     = DW'($urandom);
    cfg_trig_mode = 2'($urandom);
  endtask

  // One capture: model decides which valid frames are written.
  task automatic run_cap(input int mode, input int len_in, input int decim,
                         input int vprob, input int trig_at,
                         input int abort_at, input bit rel_after,
                         input bit rel_with_start);
    int  eff, k, got, from;
    bit  imm, ab, v, src;
    eff  = (len_in == 0 || len_in > (1 << AW)) ? (1 << AW) : len_in;
    imm  = (mode == 0 || mode == 3);
    from = imm ? 0 : trig_at + 4;
    k = 0; got = 0; ab = 0;
    src = 1'($urandom);
    if (mode == 1) begin
      ext_trig = 1'b1; repeat (2) step();
      ext_trig = 1'b0; repeat (4) step();
    end else if (mode == 2) begin
      ext_trig = 1'b1; repeat (4) step();
    end
    cfg_src_sel   = src;
    cfg_len       = len_in[AW:0];
    cfg_decim     = decim[DW-1:0];
    cfg_trig_mode = mode[1:0];
    cfg_start     = 1'b1;
    rd_release    = rel_with_start;
    step();
    cfg_start  = 1'b0;
    rd_release = 1'b0;
    junk_cfg();
    for (int i = 0; i < 3000; i++) begin
      if (!imm && i == trig_at) ext_trig = (mode == 1);
      if (mode == 1 && i == trig_at + 2) ext_trig = 1'b0;
      v = ($urandom_range(0, 99) < vprob);
      adc_valid = v;
      if (i == abort_at) begin
        cfg_abort = 1'b1;
      end else begin
        if (i >= from && v) begin
          if (k % (decim + 1) == 0) begin
            exp_q.push_back(got[AW-1:0]);
            got++;
          end
          k++;
        end
        if ($urandom_range(0, 15) == 0) cfg_start = 1'b1;
      end
      if (i == 0) begin
        @(negedge clk);
        chk("busy_on_start", busy, 1);
        chk("src_sel", src_sel, src);
      end
      step();
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      adc_valid = 1'b0;
      if (i == abort_at) begin
        ab = 1;
        break;
      end
      if (got == eff) break;
    end
    repeat (4) begin
      adc_valid = 1'($urandom);
      step();
    end
    adc_valid = 1'b0;
    @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    chk("frames_captured", frames_captured, got);
    chk("done_flag", done, !ab);
    chk("busy_after", busy, 0);
    if (rel_after) begin
      rd_release = 1'b1;
      step();
      rd_release = 1'b0;
      @(negedge clk);
      chk("done_after_release", done, 0);
      chk("busy_after_release", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 0; cfg_abort = 0; cfg_src_sel = 0;
    cfg_len = '0; cfg_decim = '0; cfg_trig_mode = '0;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
    cfg_timeout = '0;
`endif
    ext_trig = 0; adc_valid = 0; rd_release = 0;
    #22;
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_addr", buf_wr_addr, 0);
    chk("rst_src_sel", src_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames", frames_captured, 0);
`ifdef CAPTURE_TRIG_TIMEOUT_EN
    chk("rst_timed_out", timed_out, 0);
`endif
    step();
    reset = 1'b0;
    step();

    run_cap(0, 4, 0, 100, 0, -1, 1, 0);
    run_cap(3, 3, 2, 100, 0, -1, 0, 0);
    run_cap(1, 5, 1, 70, 10, -1, 1, 1);
    run_cap(0, 16, 0, 100, 0, 5, 0, 0);
    run_cap(0, 0, 0, 100, 0, -1, 0, 0);
    run_cap(0, 20, 0, 100, 0, -1, 1, 1);
    run_cap(2, 6, 0, 50, 7, -1, 1, 0);
    run_cap(1, 8, 3, 60, 3, 2, 0, 0);

    for (int r = 0; r < 12; r++) begin
      run_cap($urandom_range(0, 3), $urandom_range(0, 31),
              $urandom_range(0, 3), $urandom_range(30, 100),
              $urandom_range(1, 12),
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1,
              1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a capture.
    cfg_src_sel = 1'b1; cfg_len = 5'd8; cfg_decim = '0;
    cfg_trig_mode = 2'd0; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1;
      exp_q.push_back(i[AW-1:0]);
      step();
    end
    adc_valid = 1'b0;
    step();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_frames", frames_captured, 0);
    chk("midrst_addr", buf_wr_addr, 0);
    chk("midrst_src_sel", src_sel, 0);
    chk("midrst_outstanding", exp_q.size(), 0);
    step();
    reset = 1'b0;
    step();

`ifdef CAPTURE_TRIG_TIMEOUT_EN
    ext_trig = 1'b1;
    repeat (4) step();
    cfg_timeout = 24'd20; cfg_trig_mode = 2'd2;
    cfg_len = 5'd4; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_timeout = '0;
    for (int i = 0; i <= 20; i++) begin
      adc_valid = 1'($urandom);
      @(negedge clk);
      if (i == 19) begin
        chk("tmo_busy_before", busy, 1);
        chk("tmo_done_before", done, 0);
      end
      if (i == 20) begin
        chk("tmo_done", done, 1);
        chk("tmo_flag", timed_out, 1);
        chk("tmo_frames", frames_captured, 0);
      end
      step();
    end
    adc_valid = 1'b0;
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    @(negedge clk);
    chk("tmo_cleared", timed_out, 0);
    chk("tmo_released", done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
